// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   owner_e  : which port owns the RAM in a given cycle (none / fetch / data)
//   AW_DEF   : default RAM word-address width
//   DW_DEF   : default data width
//   addr_ok  : true when a byte address is word-aligned and inside the RAM
package mem_arb_pkg;

    localparam int unsigned AW_DEF = 10;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Shifting the whole address keeps this valid for any aw, including aw = 30.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
//   req[1:0] : request vector (bit 0 = fetch, bit 1 = data)
//   last     : 1 when bit 1 was granted most recently, 0 when bit 0 was
//   gnt[1:0] : one-hot (or zero) grant, purely combinational
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Tie: the side not granted most recently wins.
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM (1-cycle read latency)
// between an instruction-fetch port and a data load/store port.
//   clk, reset                      : clock, asynchronous active-low reset
//   i_req/i_addr                    : fetch read request, byte address
//   i_gnt/i_rdata/i_rvalid/i_err    : fetch grant, data, data valid, error
//   d_req/d_we/d_addr/d_wdata       : data request, write enable, address, write data
//   d_gnt/d_rdata/d_rvalid/d_err    : data grant, load data, load valid, error
//   m_en/m_we/m_addr/m_wdata/m_rdata: RAM port
//   stall_cnt                       : saturating count of cycles with a denied request
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic [DW-1:0] i_rdata,
    output logic          i_rvalid,
    output logic          i_err,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic          d_err,

    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,

    output logic [15:0]   stall_cnt
);

    owner_e      r_last;
    logic        r_i_rd;
    logic        r_d_rd;
    logic        r_i_err;
    logic        r_d_err;
    logic [15:0] r_stall;

    logic [1:0]  w_gnt;
    owner_e      w_owner;
    logic        w_i_ok;
    logic        w_d_ok;
    logic        w_stall;

    assign w_i_ok = addr_ok(i_addr, AW);
    assign w_d_ok = addr_ok(d_addr, AW);

    rr_arb2 u_rr (
        .req  ({d_req, i_req}),
        .last (r_last == OWN_D),
        .gnt  (w_gnt)
    );

    // Grants are suppressed while reset is held low.
    always_comb begin
        w_owner = OWN_NONE;
        if (reset) begin
            if (w_gnt[0])      w_owner = OWN_I;
            else if (w_gnt[1]) w_owner = OWN_D;
        end
    end

    assign i_gnt   = (w_owner == OWN_I);
    assign d_gnt   = (w_owner == OWN_D);
    assign w_stall = (i_req & ~i_gnt) | (d_req & ~d_gnt);

    // Invalid accesses are still granted but never touch the RAM.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = d_wdata;
        case (w_owner)
            OWN_I: begin
                if (w_i_ok) begin
                    m_en   = 1'b1;
                    m_addr = i_addr[AW+1:2];
                end
            end
            OWN_D: begin
                if (w_d_ok) begin
                    m_en   = 1'b1;
                    m_we   = d_we;
                    m_addr = d_addr[AW+1:2];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last  <= OWN_D;
            r_i_rd  <= 1'b0;
            r_d_rd  <= 1'b0;
            r_i_err <= 1'b0;
            r_d_err <= 1'b0;
            r_stall <= '0;
        end else begin
            r_i_rd  <= i_gnt & w_i_ok;
            r_i_err <= i_gnt & ~w_i_ok;
            r_d_rd  <= d_gnt & w_d_ok & ~d_we;
            r_d_err <= d_gnt & ~w_d_ok;
            if (w_owner != OWN_NONE) r_last <= w_owner;
            if (w_stall && (r_stall != '1)) r_stall <= r_stall + 16'd1;
        end
    end

    assign i_rvalid  = r_i_rd;
    assign d_rvalid  = r_d_rd;
    assign i_err     = r_i_err;
    assign d_err     = r_d_err;
    assign i_rdata   = r_i_rd ? m_rdata : '0;
    assign d_rdata   = r_d_rd ? m_rdata : '0;
    assign stall_cnt = r_stall;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, 10, memory word-address width (1024 words).
REQ-002 SHALL have parameter DW, 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_req input 1, i_addr input 32: instruction-fetch read request and byte address.
REQ-006 SHALL have ports i_gnt output 1, i_rdata output DW, i_rvalid output 1, i_err output 1: fetch grant, read data, read-data valid, fetch error.
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_addr input 32, d_wdata input DW: data-port request, write enable, byte address, write data.
REQ-008 SHALL have ports d_gnt output 1, d_rdata output DW, d_rvalid output 1, d_err output 1: data grant, load data, load valid, data error.
REQ-009 SHALL have ports m_en output 1, m_we output 1, m_addr output AW, m_wdata output DW, m_rdata input DW: single-port synchronous RAM, 1-cycle read latency.
REQ-010 SHALL have port stall_cnt  output 16  saturating count of cycles in which a request was denied.

Function
REQ-011 SHALL assert at most one of i_gnt/d_gnt per cycle; grants are combinational from req and registered state.
REQ-012 SHALL grant a lone requester in the same cycle it requests.
REQ-013 SHALL, when i_req and d_req coincide, grant the port not granted most recently (round-robin); the loser holds req, addr, wdata stable until granted.
REQ-014 SHALL drive m_en = 1, m_addr = addr[AW+1:2] of the granted port, m_we = d_gnt & d_we, m_wdata = d_wdata, for a valid access.
REQ-015 SHALL treat an access as invalid when addr[1:0] != 0 or addr[31:AW+2] != 0: grant issued, m_en = 0, matching err pulses one cycle later, no rvalid.
REQ-016 SHALL pulse i_rvalid (d_rvalid) exactly one cycle after a valid i_gnt (valid d_gnt with d_we = 0), with rdata = m_rdata that cycle; rdata = 0 when rvalid = 0.
REQ-017 SHALL produce no rvalid for writes; a write commits at the granting edge.
REQ-018 SHALL support back-to-back grants every cycle, including alternating owners, with no bubble.
REQ-019 SHALL increment stall_cnt by 1 in each cycle where a req is high without its gnt; saturate at 0xFFFF.
REQ-020 SHALL keep round-robin history unchanged in cycles with no grant.

Reset
REQ-021 SHALL, on reset low, asynchronously clear i_rvalid, d_rvalid, i_err, d_err, stall_cnt to 0 and set last-granted to D (so fetch wins the first tie).
REQ-022 SHALL force i_gnt, d_gnt, m_en, m_we to 0 while reset is low; a read granted in the cycle reset asserts yields no rvalid.
REQ-023 SHALL accept requests in the first rising edge after reset deasserts.

Structure
REQ-024 SHALL place owner encoding (OWN_NONE, OWN_I, OWN_D) and default AW/DW in shared package mem_arb_pkg.
REQ-025 SHALL implement the two-way round-robin pick as sub-module rr_arb2 (req[1:0], last, gnt[1:0]).

Verification
REQ-026 SHALL test: reset released, i_req = 1, i_addr = 0x10, RAM[4] = 0xDEADBEEF -> i_gnt same cycle, m_addr = 4, i_rvalid next cycle with i_rdata = 0xDEADBEEF.
REQ-027 SHALL test: i_req and d_req both held high 4 cycles -> grants I,D,I,D; stall_cnt = 4.
REQ-028 SHALL test: d_req, d_we = 1, d_addr = 0x20, d_wdata = 0x12345678, then d_req read 0x20 -> m_we pulse, no rvalid, then d_rdata = 0x12345678.
REQ-029 SHALL test: d_addr = 0x22 and d_addr = 0x1000 -> d_gnt, m_en = 0, d_err pulse next cycle, no d_rvalid.
REQ-030 SHALL test: reset asserted in the cycle of a read grant -> no rvalid, stall_cnt = 0, next tie after release granted to I.
